// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu; the s_hi signal exists only
// when ALU_MUL_HIGH_EN is defined.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
`ifdef ALU_MUL_HIGH_EN
   logic [WIDTH-1:0] s_hi;
`endif
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;

`ifdef ALU_MUL_HIGH_EN
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, s, s_hi, flag_z, flag_n, flag_c, flag_v
   );
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, s, s_hi, flag_z, flag_n, flag_c, flag_v
   );
`else
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, s, flag_z, flag_n, flag_c, flag_v
   );
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, s, flag_z, flag_n, flag_c, flag_v
   );
`endif
endinterface

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with iterative shift-add multiply and held results.
// Optional ALU_MUL_HIGH_EN exposes the product high half on s_hi.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     reset,
   seq_alu_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_s;
   logic               r_flag_z;
   logic               r_flag_n;
   logic               r_flag_c;
   logic               r_flag_v;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   // Upper half accumulates partial sums, lower half starts as the multiplier.
   logic [2*WIDTH-1:0] r_acc;
`ifdef ALU_MUL_HIGH_EN
   logic [WIDTH-1:0]   r_s_hi;
`endif

   logic [WIDTH-1:0]   w_x;
   logic [WIDTH-1:0]   w_y;
   logic               w_cin;
   logic               w_arith;
   logic [WIDTH-1:0]   w_logic;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_acc_next;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_x     = '0;
      w_y     = '0;
      w_cin   = 1'b0;
      w_arith = 1'b1;
      w_logic = '0;
      case (bus.op)
         3'b000: begin w_x = ~bus.a; w_cin = 1'b1; end
         3'b001: begin w_y = ~bus.b; w_cin = 1'b1; end
         3'b010: begin w_x = bus.a; w_y = bus.b; end
         3'b011: begin w_x = bus.a; w_y = ~bus.b; w_cin = 1'b1; end
         3'b100: begin w_arith = 1'b0; w_logic = bus.a & bus.b; end
         3'b101: begin w_arith = 1'b0; w_logic = bus.a | bus.b; end
         3'b111: begin w_arith = 1'b0; w_logic = bus.a ^ bus.b; end
         default: w_arith = 1'b0;
      endcase
      w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
      w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
      w_c   = w_arith & w_sum[WIDTH];
      w_v   = w_arith & (w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
   end

   always_comb begin
      w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
      w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_s         <= '0;
         r_flag_z    <= 1'b0;
         r_flag_n    <= 1'b0;
         r_flag_c    <= 1'b0;
         r_flag_v    <= 1'b0;
         r_cnt       <= '0;
         r_mcand     <= '0;
         r_acc       <= '0;
`ifdef ALU_MUL_HIGH_EN
         r_s_hi      <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_in_ready <= 1'b0;
                  if (bus.op == 3'b110) begin
                     r_mcand <= bus.a;
                     r_acc   <= {{WIDTH{1'b0}}, bus.b};
                     r_cnt   <= '0;
                     r_state <= ST_MUL;
                  end else begin
                     r_s         <= w_res;
                     r_flag_z    <= (w_res == '0);
                     r_flag_n    <= w_res[WIDTH-1];
                     r_flag_c    <= w_c;
                     r_flag_v    <= w_v;
`ifdef ALU_MUL_HIGH_EN
                     r_s_hi      <= '0;
`endif
                     r_out_valid <= 1'b1;
                     r_state     <= ST_HOLD;
                  end
               end
            end
            ST_MUL: begin
               r_acc <= w_acc_next;
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_s         <= w_acc_next[WIDTH-1:0];
                  r_flag_z    <= (w_acc_next[WIDTH-1:0] == '0);
                  r_flag_n    <= w_acc_next[WIDTH-1];
                  r_flag_c    <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_flag_v    <= |w_acc_next[2*WIDTH-1:WIDTH];
`ifdef ALU_MUL_HIGH_EN
                  r_s_hi      <= w_acc_next[2*WIDTH-1:WIDTH];
`endif
                  r_cnt       <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.s         = r_s;
   assign bus.flag_z    = r_flag_z;
   assign bus.flag_n    = r_flag_n;
   assign bus.flag_c    = r_flag_c;
   assign bus.flag_v    = r_flag_v;
`ifdef ALU_MUL_HIGH_EN
   assign bus.s_hi      = r_s_hi;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random ops against an
// arithmetic reference model; honours ALU_MUL_HIGH_EN.
module tb_seq_alu;

   localparam int W = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic [W-1:0] hi;
      logic         z, n, c, v;
   } res_t;

   function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t   r;
      longint ua, ub, sa, sb, full, sr, mask, smax, smin;
      bit     arith;
      mask  = (64'sd1 <<< W) - 1;
      smax  = (64'sd1 <<< (W - 1)) - 1;
      smin  = -(64'sd1 <<< (W - 1));
      ua    = longint'(a);
      ub    = longint'(b);
      sa    = a[W-1] ? ua - (mask + 1) : ua;
      sb    = b[W-1] ? ub - (mask + 1) : ub;
      arith = 1'b1;
      r.hi  = '0;
      r.c   = 1'b0;
      full  = 0;
      sr    = 0;
      case (op)
         3'b000: begin full = -ua;     sr = -sa;     r.c = (ua == 0); end
         3'b001: begin full = -ub;     sr = -sb;     r.c = (ub == 0); end
         3'b010: begin full = ua + ub; sr = sa + sb; r.c = (full > mask); end
         3'b011: begin full = ua - ub; sr = sa - sb; r.c = (ua >= ub); end
         3'b100: begin full = ua & ub; arith = 1'b0; end
         3'b101: begin full = ua | ub; arith = 1'b0; end
         3'b111: begin full = ua ^ ub; arith = 1'b0; end
         default: begin
            full  = ua * ub;
            arith = 1'b0;
            r.hi  = W'(full >> W);
         end
      endcase
      r.s = W'(full & mask);
      r.z = (r.s == '0);
      r.n = r.s[W-1];
      if (op == 3'b110) begin
         r.c = (r.hi != '0);
         r.v = (r.hi != '0);
      end else begin
         r.v = arith && (sr > smax || sr < smin);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_res(input res_t e);
      check("out_valid", 64'(bus.out_valid), 64'd1);
      check("s", 64'(bus.s), 64'(e.s));
`ifdef ALU_MUL_HIGH_EN
      check("s_hi", 64'(bus.s_hi), 64'(e.hi));
`endif
      check("flag_z", 64'(bus.flag_z), 64'(e.z));
      check("flag_n", 64'(bus.flag_n), 64'(e.n));
      check("flag_c", 64'(bus.flag_c), 64'(e.c));
      check("flag_v", 64'(bus.flag_v), 64'(e.v));
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!bus.in_ready && t < 64) begin
         tick();
         t++;
      end
      check("in_ready_wait", 64'(bus.in_ready), 64'd1);
   endtask

   // Issue one op, scramble the inputs after acceptance, stall the consumer, then release.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
      res_t e;
      int   lat;
      e = model(op, a, b);
      wait_ready();
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.op       = 3'($urandom);
      check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      lat = 1;
      while (!bus.out_valid && lat < 64) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), (op == 3'b110) ? 64'(W + 1) : 64'd1);
      for (int i = 0; i <= stall; i++) begin
         check_res(e);
         if (i < stall) tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("release_valid", 64'(bus.out_valid), 64'd0);
      check("release_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      res_t e1, e2;
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (2) tick();
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_s", 64'(bus.s), 64'd0);
      check("rst_flags", 64'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 64'd0);
`ifdef ALU_MUL_HIGH_EN
      check("rst_s_hi", 64'(bus.s_hi), 64'd0);
`endif
      reset = 1'b0;
      tick();

      do_op(3'b010, 8'h7F, 8'h01, 0);
      do_op(3'b011, 8'h05, 8'h05, 0);
      do_op(3'b000, 8'h00, 8'h00, 0);
      do_op(3'b001, 8'h00, 8'h01, 0);
      do_op(3'b110, 8'hFF, 8'hFF, 5);
      do_op(3'b000, 8'h80, 8'h00, 1);
      do_op(3'b011, 8'h80, 8'h01, 0);
      do_op(3'b110, 8'h0F, 8'h03, 0);

      // Reset during the 4th multiply cycle aborts the op.
      wait_ready();
      bus.op = 3'b110; bus.a = 8'h12; bus.b = 8'h34; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      check("abort_s", 64'(bus.s), 64'd0);
      do_op(3'b111, 8'hF0, 8'hFF, 0);

      // Reset coincident with in_valid must not accept the op.
      bus.op = 3'b010; bus.a = 8'h11; bus.b = 8'h22; bus.in_valid = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; bus.in_valid = 1'b0;
      tick();
      check("rst_accept_valid", 64'(bus.out_valid), 64'd0);
      check("rst_accept_ready", 64'(bus.in_ready), 64'd1);

      // Back-to-back throughput with out_ready held high.
      e1 = model(3'b010, 8'h21, 8'h13);
      e2 = model(3'b101, 8'h0C, 8'h30);
      bus.out_ready = 1'b1;
      bus.op = 3'b010; bus.a = 8'h21; bus.b = 8'h13; bus.in_valid = 1'b1;
      tick();
      bus.op = 3'b101; bus.a = 8'h0C; bus.b = 8'h30;
      check_res(e1);
      check("tp_busy", 64'(bus.in_ready), 64'd0);
      tick();
      check("tp_idle_ready", 64'(bus.in_ready), 64'd1);
      check("tp_idle_valid", 64'(bus.out_valid), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      check_res(e2);
      tick();
      bus.out_ready = 1'b0;
      check("tp_end_ready", 64'(bus.in_ready), 64'd1);

      for (int i = 0; i < 40; i++) begin
         do_op(3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
